// File: rtl/pmod_ad1_pkg.sv
// Shared definitions for the PMOD AD1 (dual AD7476A) SPI responder emulator.
// Holds the default frame geometry, the sample field offsets inside the
// {ch1, ch0} sample word, and the frame state encoding.
package pmod_ad1_pkg;

  localparam int DATA_BITS  = 12;
  localparam int LEAD_ZEROS = 3;
  localparam int FRAME_BITS = 16;

  // Offsets of each channel inside the packed sample word.
  localparam int CH0_LSB = 0;
  localparam int CH1_LSB = DATA_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pmod_ad1_sync_edge_detect.sv
// Synchroniser plus edge detector for one asynchronous input pin.
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset; chain and history go to RESET_VAL
//   d      - asynchronous input pin
//   level  - synchronised level
//   rise   - one-cycle high when the synchronised level goes 0 -> 1
//   fall   - one-cycle high when the synchronised level goes 1 -> 0
module sync_edge_detect
  import pmod_ad1_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // The synchroniser shifts the pin in at bit 0; prev_q is one cycle behind
  // the last stage so that edges are a pure compare of two registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/pmod_ad1_responder.sv
// SPI responder emulating the two AD7476A converters of a PMOD AD1.
// Fabric pushes {ch1, ch0} samples through a valid/ready holding register;
// each chip-select frame shifts LEAD_ZEROS zeros, then DATA_BITS of data
// MSB first, then releases the line for the final slot.
// Ports:
//   clk_i, rst_i        - system clock (>= 4x SCLK), async active-high reset
//   sample_valid_i/_i   - sample handshake input, sample_i = {ch1, ch0}
//   sample_ready_o      - holding register empty
//   sclk_i, cs_n_i      - asynchronous SPI clock and chip select
//   sdata_o, sdata_oe_o - per-channel serial data and output enable
//   frame_done_o        - pulse on cs rise after a complete frame
//   abort_o             - pulse on cs rise before the frame completed
//   underrun_o          - pulse when a frame starts with no fresh sample
module pmod_ad1_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = pmod_ad1_pkg::DATA_BITS,
  parameter int LEAD_ZEROS  = pmod_ad1_pkg::LEAD_ZEROS,
  parameter int FRAME_BITS  = pmod_ad1_pkg::FRAME_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sample_valid_i,
  output logic                   sample_ready_o,
  input  logic [2*DATA_BITS-1:0] sample_i,
  input  logic                   sclk_i,
  input  logic                   cs_n_i,
  output logic [1:0]             sdata_o,
  output logic [1:0]             sdata_oe_o,
  output logic                   frame_done_o,
  output logic                   abort_o,
  output logic                   underrun_o
);
  import pmod_ad1_pkg::*;

  localparam int CNT_W    = $clog2(FRAME_BITS);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(FRAME_BITS - 2);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic unused_sclk;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (cs_n_i),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (sclk_i),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign unused_sclk = &{1'b0, sclk_level, sclk_rise};

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*DATA_BITS-1:0] frame_q, frame_d;
  logic [2*DATA_BITS-1:0] hold_q, hold_d;
  logic [2*DATA_BITS-1:0] last_q, last_d;
  logic                   hold_full_q, hold_full_d;
  logic                   armed_q;
  logic [SETTLE_W-1:0]    settle_q;
  logic                   settled;
  logic                   transfer;
  logic                   oe_d;
  logic [1:0]             sdata_d;
  logic                   done_d, abort_d, underrun_d;

  assign sample_ready_o = ~hold_full_q;
  assign transfer       = sample_valid_i && sample_ready_o;

  // The synchronisers come out of reset reading cs_n high, so a pin that is
  // already low shows up as a false fall. A frame may only start once the
  // chain has flushed and cs_n has genuinely been seen high.
  assign settled = (settle_q == SETTLE_W'(SYNC_STAGES));

  // Wire value of one channel in a given slot: zeros, then data MSB first.
  function automatic logic slot_bit(input logic [DATA_BITS-1:0] ch,
                                    input logic [CNT_W-1:0]     slot);
    int idx;
    logic [DATA_BITS-1:0] shifted;
    idx = DATA_BITS - 1 - (int'(slot) - LEAD_ZEROS);
    if (int'(slot) < LEAD_ZEROS || idx < 0) return 1'b0;
    shifted = ch >> idx;
    return shifted[0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    underrun_d  = 1'b0;

    if (transfer) begin
      hold_d      = sample_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          if (hold_full_q) begin
            frame_d     = hold_q;
            last_d      = hold_q;
            hold_full_d = 1'b0;
          end else if (transfer) begin
            // Bypass: the sample goes straight to the wire, holding stays empty.
            frame_d     = sample_i;
            last_d      = sample_i;
            hold_full_d = 1'b0;
          end else begin
            frame_d    = last_q;
            underrun_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // cs rise has priority over a coincident sclk fall.
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (sclk_fall) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_SHIFT) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    oe_d    = (state_d == ST_SHIFT);
    sdata_d = 2'b00;
    if (oe_d) begin
      sdata_d = {slot_bit(frame_d[CH0_LSB + DATA_BITS +: DATA_BITS], cnt_d),
                 slot_bit(frame_d[CH0_LSB +: DATA_BITS], cnt_d)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      frame_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_q       <= '0;
      armed_q      <= 1'b0;
      settle_q     <= '0;
      sdata_o      <= 2'b00;
      sdata_oe_o   <= 2'b00;
      frame_done_o <= 1'b0;
      abort_o      <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      last_q       <= last_d;
      armed_q      <= armed_q | (settled & cs_level);
      if (!settled) settle_q <= settle_q + SETTLE_W'(1);
      sdata_o      <= sdata_d;
      sdata_oe_o   <= {2{oe_d}};
      frame_done_o <= done_d;
      abort_o      <= abort_d;
      underrun_o   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pmod_ad1_responder.sv
// Scoreboard bench for pmod_ad1_responder: stimulus pushes expected wire
// slots and expected pulses into queues; monitors pop and compare them.
module tb_pmod_ad1_responder;

  localparam int SYNC = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic [23:0] sample_i = '0;
  logic        sclk_i = 1'b1;
  logic        cs_n_i = 1'b1;
  logic [1:0]  sdata_o;
  logic [1:0]  sdata_oe_o;
  logic        frame_done_o;
  logic        abort_o;
  logic        underrun_o;

  typedef struct {
    int         slot;
    logic [3:0] val;
  } slot_exp_t;

  int        testsRun = 0;
  int        testsFailed = 0;
  slot_exp_t slotQ[$];
  logic [2:0] eventQ[$];
  slot_exp_t monE;

  always #5 clk_i = ~clk_i;

  pmod_ad1_responder dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .sample_i       (sample_i),
    .sclk_i         (sclk_i),
    .cs_n_i         (cs_n_i),
    .sdata_o        (sdata_o),
    .sdata_oe_o     (sdata_oe_o),
    .frame_done_o   (frame_done_o),
    .abort_o        (abort_o),
    .underrun_o     (underrun_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected {oe, ch1, ch0} for a slot; slots past the data are released.
  function automatic logic [3:0] expSlot(input logic [11:0] c1,
                                         input logic [11:0] c0,
                                         input int slot);
    logic [11:0] t1, t0;
    if (slot < 3) return 4'b1100;
    if (slot > 14) return 4'b0000;
    t1 = c1 >> (14 - slot);
    t0 = c0 >> (14 - slot);
    return {2'b11, t1[0], t0[0]};
  endfunction

  task automatic sclkPulse();
    sclk_i = 1'b0;
    #25;
    sclk_i = 1'b1;
    #25;
  endtask

  task automatic pushSample(input logic [11:0] c1, input logic [11:0] c0);
    int n = 0;
    @(negedge clk_i);
    while (!sample_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("ready_before_push", 32'(sample_ready_o), 32'd1);
    sample_valid_i = 1'b1;
    sample_i       = {c1, c0};
    @(negedge clk_i);
    sample_valid_i = 1'b0;
    checkOutput("ready_after_push", 32'(sample_ready_o), 32'd0);
  endtask

  // One frame as SPI initiator; expectations queued before driving pins.
  task automatic applyStimulus(input logic [11:0] c1, input logic [11:0] c0,
                               input int nFalls, input bit abortFrame,
                               input bit expUnderrun, input bit bypass);
    if (expUnderrun) eventQ.push_back(3'b001);
    for (int k = 0; k < nFalls; k++)
      slotQ.push_back('{k, expSlot(c1, c0, (k > 15) ? 15 : k)});
    @(negedge clk_i);
    cs_n_i = 1'b0;
    if (bypass) begin
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      sample_valid_i = 1'b1;
      sample_i       = {c1, c0};
      @(posedge clk_i);
      #1;
      sample_valid_i = 1'b0;
      #28;
    end else begin
      #50;
    end
    checkOutput("ready_after_csfall", 32'(sample_ready_o), 32'd1);
    for (int k = 0; k < nFalls; k++) sclkPulse();
    if (abortFrame) begin
      eventQ.push_back(3'b010);
      checkOutput("oe_before_abort", 32'(sdata_oe_o), 32'd3);
      cs_n_i = 1'b1;
      repeat (SYNC + 1) @(posedge clk_i);
      #1;
      checkOutput("oe_after_abort", 32'(sdata_oe_o), 32'd0);
    end else begin
      eventQ.push_back(3'b100);
      cs_n_i = 1'b1;
    end
    #200;
    checkOutput("oe_idle_after_frame", 32'(sdata_oe_o), 32'd0);
    checkOutput("slotq_empty", 32'(slotQ.size()), 32'd0);
    checkOutput("eventq_empty", 32'(eventQ.size()), 32'd0);
  endtask

  always @(negedge sclk_i) begin
    if (!cs_n_i) begin
      if (slotQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL slot_unexpected: got %b, expected no sample", {sdata_oe_o, sdata_o});
      end else begin
        monE = slotQ.pop_front();
        checkOutput($sformatf("slot%0d", monE.slot), 32'({sdata_oe_o, sdata_o}), 32'(monE.val));
      end
    end
  end

  always @(negedge clk_i) begin
    if (frame_done_o || abort_o || underrun_o) begin
      if (eventQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL event_unexpected: got %b, expected none", {frame_done_o, abort_o, underrun_o});
      end else begin
        checkOutput("event", 32'({frame_done_o, abort_o, underrun_o}), 32'(eventQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    checkOutput("rst_sdata", 32'(sdata_o), 32'd0);
    checkOutput("rst_oe", 32'(sdata_oe_o), 32'd0);
    checkOutput("rst_ready", 32'(sample_ready_o), 32'd1);
    checkOutput("rst_pulses", 32'({frame_done_o, abort_o, underrun_o}), 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);

    // Basic frame from the holding register.
    pushSample(12'hA5C, 12'h3F1);
    applyStimulus(12'hA5C, 12'h3F1, 16, 1'b0, 1'b0, 1'b0);

    // No new sample: last sample repeats with an underrun.
    applyStimulus(12'hA5C, 12'h3F1, 16, 1'b0, 1'b1, 1'b0);

    // Sample offered in the same cycle as the synchronised cs fall.
    applyStimulus(12'h800, 12'h001, 16, 1'b0, 1'b0, 1'b1);

    // Aborted frame after 6 falls, then a clean frame.
    pushSample(12'h7E4, 12'h18B);
    applyStimulus(12'h7E4, 12'h18B, 6, 1'b1, 1'b0, 1'b0);
    pushSample(12'h2C9, 12'hD36);
    applyStimulus(12'h2C9, 12'hD36, 16, 1'b0, 1'b0, 1'b0);

    // Extra SCLK pulses past the end of the frame.
    pushSample(12'h0FF, 12'hF00);
    applyStimulus(12'h0FF, 12'hF00, 20, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame with cs held low.
    pushSample(12'h5A5, 12'h3C3);
    for (int k = 0; k < 8; k++) slotQ.push_back('{k, expSlot(12'h5A5, 12'h3C3, k)});
    @(negedge clk_i);
    cs_n_i = 1'b0;
    #50;
    for (int k = 0; k < 8; k++) sclkPulse();
    checkOutput("oe_slot8", 32'(sdata_oe_o), 32'd3);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("rst_mid_oe", 32'(sdata_oe_o), 32'd0);
    checkOutput("rst_mid_sdata", 32'(sdata_o), 32'd0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) slotQ.push_back('{100 + k, 4'b0000});
    for (int k = 0; k < 4; k++) sclkPulse();
    #100;
    checkOutput("idle_after_rst_oe", 32'(sdata_oe_o), 32'd0);
    checkOutput("ready_after_rst", 32'(sample_ready_o), 32'd1);
    checkOutput("rst_slotq_empty", 32'(slotQ.size()), 32'd0);
    cs_n_i = 1'b1;
    #100;
    pushSample(12'h96E, 12'h1B7);
    applyStimulus(12'h96E, 12'h1B7, 16, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pmod_ad1_responder.md
Name: pmod_ad1_responder

Overview:
- Synthesizable emulator of the AD7476A pair on the PMOD AD1: the SPI responder side of the ADC link. Two channels share one SCLK/CS_N and have separate SDATA lines.
- Lets a second FPGA, or a loopback on the same board, exercise the SPI initiator and the sample path without real ADC hardware.
- Fabric logic supplies two 12-bit samples through a valid/ready handshake. The block serialises them onto SDATA with AD7476A framing.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on sclk_i and cs_n_i before edge detection (minimum 2).
- DATA_BITS, 12, converter resolution per channel.
- LEAD_ZEROS, 3, zero slots driven before data MSB.
- FRAME_BITS, 16, total SCLK slots per frame; the last slot is high-Z.

Ports:
- clk_i  in  1  system clock; must be at least 4x the SCLK frequency.
- rst_i  in  1  reset, asynchronous, active-high.
- sample_valid_i  in  1  sample_i is valid.
- sample_ready_o  out  1  holding register is empty and accepts a sample.
- sample_i  in  2*DATA_BITS  {ch1, ch0}; ch0 drives sdata_o[0].
- sclk_i  in  1  SPI clock from the initiator; asynchronous.
- cs_n_i  in  1  SPI chip select, active low; asynchronous.
- sdata_o  out  2  serial data per channel.
- sdata_oe_o  out  2  output enable per channel; both bits are always equal.
- frame_done_o  out  1  one-cycle pulse when a frame completes normally.
- abort_o  out  1  one-cycle pulse when cs_n_i rises before the frame completes.
- underrun_o  out  1  one-cycle pulse when a frame starts with an empty holding register.

Behaviour:
- Reset values (asynchronous): sdata_o=0, sdata_oe_o=0, sample_ready_o=1, all pulses=0.
- Reset also sets: holding register empty, last-sample register 0, state IDLE, slot counter 0.
- Synchronisers reset to cs_n high and sclk high.
- Edges are detected on the synchronised signals: cs_fall, cs_rise, sclk_fall.
- Pin-to-output latency is SYNC_STAGES+1 clk_i cycles.
- Handshake: a transfer occurs when sample_valid_i && sample_ready_o. The sample is captured into the holding register, and sample_ready_o drops the next cycle.
- Frame load rules on cs_fall (in IDLE):
  - Holding register full: its content is loaded into the shift register and into last-sample, the holding register is marked empty, and sample_ready_o rises the next cycle.
  - Holding register empty with a transfer in the same cycle: the new sample is loaded directly (bypass). The holding register stays empty and no underrun is flagged.
  - Holding register empty with no transfer: last-sample is reloaded and underrun_o pulses.
- Wire slot layout: slots 0..LEAD_ZEROS-1 = 0; next DATA_BITS slots = data MSB first; final slot high-Z (oe=0). With defaults: slots 0-2 zero, 3-14 data[11:0], 15 high-Z.
- Slot advance:
  - Slot 0 is driven (oe=1) in the cycle after cs_fall is detected.
  - Each sclk_fall advances one slot.
  - After the (FRAME_BITS-1)th sclk_fall the block is in slot 15: oe=0, sdata_o=0.
- State machine:
  - IDLE --cs_fall--> SHIFT.
  - SHIFT --sclk_fall with counter=FRAME_BITS-2--> DONE.
  - SHIFT --cs_rise--> IDLE, oe=0, abort_o pulses.
  - DONE --cs_rise--> IDLE, frame_done_o pulses.
  - DONE: further sclk_fall edges are ignored and outputs stay high-Z.
- sclk edges while in IDLE are ignored.
- A cs_fall and cs_rise cannot coincide after synchronisation. cs_rise and sclk_fall in the same cycle: cs_rise wins.
- A held or new sample does not change an in-flight frame; the shift register is loaded only at cs_fall.
- Mid-frame reset: outputs go high-Z immediately (asynchronously). The next frame starts only on a fresh cs_fall after reset is released. If cs_n_i is still low at release, the block waits in IDLE.
- The slot counter is a clog2(FRAME_BITS)-bit counter with no wrap: it saturates in DONE.

Decomposition:
- Shared package pmod_ad1_pkg:
  - FRAME_BITS, LEAD_ZEROS, DATA_BITS constants.
  - State encoding (IDLE, SHIFT, DONE).
  - Sample field offsets: ch0 at bit 0, ch1 at bit DATA_BITS.
- One sub-module: sync_edge_detect. It holds the SYNC_STAGES synchroniser plus a registered previous value, with outputs level, rise and fall. It is instantiated twice, for cs_n_i and sclk_i.

Test Plan:
- Push {ch1=12'hA5C, ch0=12'h3F1}, then run one 20 MHz frame (clk 100 MHz, 16 SCLK) -> captured bits ch0 = 000_0011_1111_0001_Z, ch1 = 000_1010_0101_1100_Z; frame_done_o pulses once after cs rise; sample_ready_o is 1 after cs_fall.
- Two frames with no new sample before the second -> second frame repeats 12'hA5C/12'h3F1 and underrun_o pulses exactly once, at the second cs_fall.
- sample_valid_i asserted in the same cycle as the synchronised cs_fall with the holding register empty, sample 12'h001 -> frame carries 12'h001 and no underrun_o.
- cs_n_i raised after 6 SCLK falling edges -> sdata_oe_o=0 within SYNC_STAGES+1 cycles, abort_o pulses, no frame_done_o; the next full frame is correct.
- 20 SCLK pulses in one frame -> slots 16-19 stay high-Z; one frame_done_o.
- rst_i asserted mid-frame (slot 8) for 1 cycle with cs_n_i held low -> outputs go high-Z immediately and stay idle until cs_n_i toggles high then low; the following frame is correct from slot 0.
